// File: rtl/rf_psum_pingpong_drain.sv
// ---------------------------------------------------------------------------
// rf_psum_pingpong_drain
//   Ping-pong partial-sum register file for one PE. The compute side reads,
//   writes or accumulates psums in the compute bank, while an internal FSM
//   streams the other bank to the global buffer over a valid/ready link.
//   Entries carry a valid bit that is cleared on swap, so a freshly handed-
//   over bank reads as all zeros without spending any clear cycles.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   i_swap_req      request a bank role swap (held until o_swap_ack)
//   o_swap_ack      swap accepted this cycle (combinational pulse)
//   o_comp_bank     bank currently owned by the compute side
//   i_rd_addr       compute read address
//   o_rd_data       registered read data, 1-cycle latency, write-first
//   i_wr_en         compute write strobe
//   i_wr_addr       compute write address
//   i_wr_data       compute write data
//   i_acc_en        1: accumulate into stored value, 0: overwrite
//   o_drain_valid   drain word available
//   i_drain_ready   global buffer accepts the drain word
//   o_drain_addr    entry index of o_drain_data
//   o_drain_data    drained word (0 for entries never written)
//   o_drain_done    pulse the cycle after the last drain word is accepted
// ---------------------------------------------------------------------------
module rf_psum_pingpong_drain #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 3,
    parameter int DEPTH         = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_swap_req,
    output logic                     o_swap_ack,
    output logic                     o_comp_bank,
    input  logic [ADDR_BITWIDTH-1:0] i_rd_addr,
    output logic [DATA_BITWIDTH-1:0] o_rd_data,
    input  logic                     i_wr_en,
    input  logic [ADDR_BITWIDTH-1:0] i_wr_addr,
    input  logic [DATA_BITWIDTH-1:0] i_wr_data,
    input  logic                     i_acc_en,
    output logic                     o_drain_valid,
    input  logic                     i_drain_ready,
    output logic [ADDR_BITWIDTH-1:0] o_drain_addr,
    output logic [DATA_BITWIDTH-1:0] o_drain_data,
    output logic                     o_drain_done
);

    localparam int DW = DATA_BITWIDTH;
    localparam int AW = ADDR_BITWIDTH;
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [DW-1:0]    r_mem [2][DEPTH];
    logic [DEPTH-1:0] r_valid [2];
    logic             r_comp_bank;
    logic [AW-1:0]    r_drain_addr;
    logic             r_drain_done;
    logic [DW-1:0]    r_rd_data;

    logic             w_drain_bank;
    logic             w_wr_hit;
    logic             w_rd_in_range;
    logic [DW-1:0]    w_wr_old;
    logic [DW-1:0]    w_wr_value;
    logic [DW-1:0]    w_rd_eff;
    logic [DW-1:0]    w_drain_eff;
    logic             w_swap_ack;
    logic             w_handshake;
    logic             w_last;

    assign w_drain_bank  = ~r_comp_bank;
    // Out-of-range addresses are compared with one extra bit so the test
    // stays meaningful when DEPTH is smaller than 2**AW.
    assign w_wr_hit      = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_EXT);
    assign w_rd_in_range = ({1'b0, i_rd_addr} < DEPTH_EXT);

    // Effective values: an entry whose valid bit is clear reads as zero.
    assign w_wr_old    = r_valid[r_comp_bank][i_wr_addr] ? r_mem[r_comp_bank][i_wr_addr] : '0;
    assign w_wr_value  = i_acc_en ? (w_wr_old + i_wr_data) : i_wr_data;
    assign w_rd_eff    = r_valid[r_comp_bank][i_rd_addr] ? r_mem[r_comp_bank][i_rd_addr] : '0;
    assign w_drain_eff = r_valid[w_drain_bank][r_drain_addr] ? r_mem[w_drain_bank][r_drain_addr] : '0;

    // A swap is only taken while no drain is in flight; reset masks it so
    // the acknowledge never fires during the reset cycle itself.
    assign w_swap_ack  = i_swap_req && (r_state == S_IDLE) && !reset;
    assign w_handshake = (r_state == S_DRAIN) && i_drain_ready;
    assign w_last      = w_handshake && (r_drain_addr == LAST_ADDR);

    // Drain FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_swap_ack) w_state_next = S_DRAIN;
            S_DRAIN: if (w_last)     w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Bank ownership, drain pointer and completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_comp_bank  <= 1'b0;
            r_drain_addr <= '0;
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= w_last;
            if (w_swap_ack) begin
                r_comp_bank  <= ~r_comp_bank;
                r_drain_addr <= '0;
            end else if (w_handshake) begin
                r_drain_addr <= w_last ? '0 : (r_drain_addr + AW'(1));
            end
        end
    end

    // Valid bits: the bank handed to compute on swap is wiped, and a write
    // in the swap cycle still marks the outgoing bank so it gets drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid[0] <= '0;
            r_valid[1] <= '0;
        end else begin
            if (w_swap_ack) r_valid[w_drain_bank] <= '0;
            if (w_wr_hit)   r_valid[r_comp_bank][i_wr_addr] <= 1'b1;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_hit) r_mem[r_comp_bank][i_wr_addr] <= w_wr_value;
    end

    // Registered compute read with write-first forwarding.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (!w_rd_in_range) begin
            r_rd_data <= '0;
        end else if (w_wr_hit && (i_wr_addr == i_rd_addr)) begin
            r_rd_data <= w_wr_value;
        end else begin
            r_rd_data <= w_rd_eff;
        end
    end

    assign o_swap_ack    = w_swap_ack;
    assign o_comp_bank   = r_comp_bank;
    assign o_rd_data     = r_rd_data;
    assign o_drain_valid = (r_state == S_DRAIN);
    assign o_drain_addr  = r_drain_addr;
    assign o_drain_data  = w_drain_eff;
    assign o_drain_done  = r_drain_done;

endmodule
